// File: rtl/virtio_mmio_regs_pkg.sv
// Shared constants for the virtio-mmio register block: offsets, ID values, response codes.
package virtio_params;

    localparam logic [11:0] OFF_MAGIC           = 12'h000;
    localparam logic [11:0] OFF_VERSION         = 12'h004;
    localparam logic [11:0] OFF_DEVICE_ID       = 12'h008;
    localparam logic [11:0] OFF_VENDOR          = 12'h00C;
    localparam logic [11:0] OFF_HOST_FEAT       = 12'h010;
    localparam logic [11:0] OFF_HOST_FEAT_SEL   = 12'h014;
    localparam logic [11:0] OFF_GUEST_FEAT      = 12'h020;
    localparam logic [11:0] OFF_GUEST_FEAT_SEL  = 12'h024;
    localparam logic [11:0] OFF_GUEST_PAGE_SIZE = 12'h028;
    localparam logic [11:0] OFF_QUEUE_SEL       = 12'h030;
    localparam logic [11:0] OFF_QUEUE_NUM_MAX   = 12'h034;
    localparam logic [11:0] OFF_QUEUE_NUM       = 12'h038;
    localparam logic [11:0] OFF_QUEUE_ALIGN     = 12'h03C;
    localparam logic [11:0] OFF_QUEUE_PFN       = 12'h040;
    localparam logic [11:0] OFF_QUEUE_NOTIFY    = 12'h050;
    localparam logic [11:0] OFF_INT_STATUS      = 12'h060;
    localparam logic [11:0] OFF_INT_ACK         = 12'h064;
    localparam logic [11:0] OFF_STATUS          = 12'h070;
    localparam logic [11:0] OFF_CONFIG_LO       = 12'h100;
    localparam logic [11:0] OFF_CONFIG_HI       = 12'h104;

    localparam logic [31:0] MAGIC_VALUE   = 32'h7472_6976;
    localparam logic [31:0] VERSION_VALUE = 32'd1;
    localparam logic [31:0] VENDOR_VALUE  = 32'h554D_4551;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;

    // Only full-word writes take effect; partial strobes are acknowledged but dropped.
    function automatic logic full_word(input logic [3:0] strb);
        return (strb == 4'hF);
    endfunction

endpackage

// File: rtl/virtio_notify_fifo.sv
// Small synchronous FIFO carrying queue-notify indices to the controller.
module virtio_notify_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr_r == rd_ptr_r);
    assign full     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_data = mem_r[rd_ptr_r[AW-1:0]];

    // Storage and pointer update; the caller only pushes when a slot is free or being popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/virtio_mmio_regs.sv
// virtio-mmio (legacy) register block behind an AXI4-Lite slave, with notify FIFO and interrupt status.
module virtio_mmio_regs
    import virtio_params::*;
#(
    parameter int          NUM_QUEUES    = 2,
    parameter int          QUEUE_NUM_MAX = 8,
    parameter int          NOTIFY_DEPTH  = 4,
    parameter logic [31:0] DEVICE_ID     = 32'h2,
    localparam int         QW            = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                core_araddr,
    input  logic                       core_arvalid,
    output logic                       core_arready,
    input  logic [2:0]                 core_arprot,
    output logic [31:0]                core_rdata,
    output logic [1:0]                 core_rresp,
    output logic                       core_rvalid,
    input  logic                       core_rready,
    input  logic [31:0]                core_awaddr,
    input  logic                       core_awvalid,
    output logic                       core_awready,
    input  logic [2:0]                 core_awprot,
    input  logic [31:0]                core_wdata,
    input  logic [3:0]                 core_wstrb,
    input  logic                       core_wvalid,
    output logic                       core_wready,
    output logic [1:0]                 core_bresp,
    output logic                       core_bvalid,
    input  logic                       core_bready,
    input  logic [63:0]                capacity,
    output logic                       notify_valid,
    output logic [QW-1:0]              notify_queue,
    input  logic                       notify_ready,
    output logic [NUM_QUEUES*32-1:0]   q_pfn,
    output logic [NUM_QUEUES*32-1:0]   q_num,
    output logic [NUM_QUEUES*32-1:0]   q_align,
    output logic [31:0]                guest_page_size,
    input  logic                       used_irq,
    input  logic                       config_irq,
    output logic                       virtio_interrupt,
    output logic                       device_reset
);

    logic        arready_r, rvalid_r, awready_r, wready_r, bvalid_r;
    logic [31:0] rdata_r;
    logic [11:0] aw_addr_r;
    logic [31:0] w_data_r;
    logic [3:0]  w_strb_r;
    logic [31:0] host_feat_sel_r, guest_feat_r, guest_feat_sel_r, guest_page_size_r;
    logic [31:0] queue_sel_r, status_r;
    logic [31:0] q_num_r [NUM_QUEUES];
    logic [31:0] q_align_r [NUM_QUEUES];
    logic [31:0] q_pfn_r [NUM_QUEUES];
    logic [1:0]  int_status_r;
    logic        virtio_interrupt_r, device_reset_r;

    logic        q_ok_s, wr_en_s, push_req_s, commit_s, pop_s, dev_reset_s;
    logic        fifo_full_s, fifo_empty_s;
    logic [QW-1:0] qi_s;
    logic [31:0] rd_data_s;
    logic [1:0]  ack_mask_s;
    logic        unused_s;

    assign unused_s = ^{core_arprot, core_awprot, core_araddr[31:12], core_awaddr[31:12]};

    assign core_arready     = arready_r;
    assign core_rvalid      = rvalid_r;
    assign core_rdata       = rdata_r;
    assign core_rresp       = RESP_OKAY;
    assign core_awready     = awready_r;
    assign core_wready      = wready_r;
    assign core_bvalid      = bvalid_r;
    assign core_bresp       = RESP_OKAY;
    assign guest_page_size  = guest_page_size_r;
    assign virtio_interrupt = virtio_interrupt_r;
    assign device_reset     = device_reset_r;
    assign notify_valid     = !fifo_empty_s;

    for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_flat
        assign q_pfn[32*gi +: 32]   = q_pfn_r[gi];
        assign q_num[32*gi +: 32]   = q_num_r[gi];
        assign q_align[32*gi +: 32] = q_align_r[gi];
    end

    // Queue selection, commit gating (stalls on a full notify FIFO) and interrupt-ack decode.
    always_comb begin
        q_ok_s      = (queue_sel_r < 32'(NUM_QUEUES));
        qi_s        = queue_sel_r[QW-1:0];
        pop_s       = !fifo_empty_s && notify_ready;
        push_req_s  = full_word(w_strb_r) && (aw_addr_r == OFF_QUEUE_NOTIFY)
                      && (w_data_r < 32'(NUM_QUEUES));
        commit_s    = !awready_r && !wready_r && !bvalid_r
                      && (!push_req_s || !fifo_full_s || pop_s);
        wr_en_s     = commit_s && full_word(w_strb_r);
        dev_reset_s = wr_en_s && (aw_addr_r == OFF_STATUS) && (w_data_r == 32'd0);
        if (wr_en_s && (aw_addr_r == OFF_INT_ACK)) begin
            ack_mask_s = w_data_r[1:0];
        end else begin
            ack_mask_s = 2'b00;
        end
    end

    // Read data multiplexer; sampled at the AR handshake so a same-cycle write is not visible.
    always_comb begin
        rd_data_s = 32'd0;
        case (core_araddr[11:0])
            OFF_MAGIC:           rd_data_s = MAGIC_VALUE;
            OFF_VERSION:         rd_data_s = VERSION_VALUE;
            OFF_DEVICE_ID:       rd_data_s = DEVICE_ID;
            OFF_VENDOR:          rd_data_s = VENDOR_VALUE;
            OFF_HOST_FEAT_SEL:   rd_data_s = host_feat_sel_r;
            OFF_GUEST_FEAT:      rd_data_s = guest_feat_r;
            OFF_GUEST_FEAT_SEL:  rd_data_s = guest_feat_sel_r;
            OFF_GUEST_PAGE_SIZE: rd_data_s = guest_page_size_r;
            OFF_QUEUE_SEL:       rd_data_s = queue_sel_r;
            OFF_QUEUE_NUM_MAX:   rd_data_s = q_ok_s ? 32'(QUEUE_NUM_MAX) : 32'd0;
            OFF_QUEUE_NUM:       rd_data_s = q_ok_s ? q_num_r[qi_s] : 32'd0;
            OFF_QUEUE_ALIGN:     rd_data_s = q_ok_s ? q_align_r[qi_s] : 32'd0;
            OFF_QUEUE_PFN:       rd_data_s = q_ok_s ? q_pfn_r[qi_s] : 32'd0;
            OFF_INT_STATUS:      rd_data_s = {30'd0, int_status_r};
            OFF_STATUS:          rd_data_s = status_r;
            OFF_CONFIG_LO:       rd_data_s = capacity[31:0];
            OFF_CONFIG_HI:       rd_data_s = capacity[63:32];
            default:             rd_data_s = 32'd0;
        endcase
    end

    // AXI read channel: one outstanding read, data registered one cycle after AR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'd0;
        end else if (core_arvalid && arready_r) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
            rdata_r   <= rd_data_s;
        end else if (rvalid_r && core_rready) begin
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
        end
    end

    // AXI write channel: capture AW and W independently, respond on commit, reopen after B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
            bvalid_r  <= 1'b0;
            aw_addr_r <= 12'd0;
            w_data_r  <= 32'd0;
            w_strb_r  <= 4'd0;
        end else begin
            if (core_awvalid && awready_r) begin
                aw_addr_r <= core_awaddr[11:0];
                awready_r <= 1'b0;
            end
            if (core_wvalid && wready_r) begin
                w_data_r <= core_wdata;
                w_strb_r <= core_wstrb;
                wready_r <= 1'b0;
            end
            if (commit_s) begin
                bvalid_r <= 1'b1;
            end else if (bvalid_r && core_bready) begin
                bvalid_r  <= 1'b0;
                awready_r <= 1'b1;
                wready_r  <= 1'b1;
            end
        end
    end

    // Writable register file; a Status write of zero returns the device to its initial state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_feat_sel_r   <= 32'd0;
            guest_feat_r      <= 32'd0;
            guest_feat_sel_r  <= 32'd0;
            guest_page_size_r <= 32'd0;
            queue_sel_r       <= 32'd0;
            status_r          <= 32'd0;
            device_reset_r    <= 1'b0;
            for (int i = 0; i < NUM_QUEUES; i++) begin
                q_num_r[i]   <= 32'd0;
                q_align_r[i] <= 32'd0;
                q_pfn_r[i]   <= 32'd0;
            end
        end else begin
            device_reset_r <= dev_reset_s;
            if (dev_reset_s) begin
                host_feat_sel_r  <= 32'd0;
                guest_feat_r     <= 32'd0;
                guest_feat_sel_r <= 32'd0;
                queue_sel_r      <= 32'd0;
                status_r         <= 32'd0;
                for (int i = 0; i < NUM_QUEUES; i++) begin
                    q_num_r[i]   <= 32'd0;
                    q_align_r[i] <= 32'd0;
                    q_pfn_r[i]   <= 32'd0;
                end
            end else if (wr_en_s) begin
                case (aw_addr_r)
                    OFF_HOST_FEAT_SEL:   host_feat_sel_r   <= w_data_r;
                    OFF_GUEST_FEAT:      guest_feat_r      <= w_data_r;
                    OFF_GUEST_FEAT_SEL:  guest_feat_sel_r  <= w_data_r;
                    OFF_GUEST_PAGE_SIZE: guest_page_size_r <= w_data_r;
                    OFF_QUEUE_SEL:       queue_sel_r       <= w_data_r;
                    OFF_STATUS:          status_r          <= w_data_r;
                    OFF_QUEUE_NUM: begin
                        if (q_ok_s && (w_data_r <= 32'(QUEUE_NUM_MAX))) begin
                            q_num_r[qi_s] <= w_data_r;
                        end
                    end
                    OFF_QUEUE_ALIGN: begin
                        if (q_ok_s) begin
                            q_align_r[qi_s] <= w_data_r;
                        end
                    end
                    OFF_QUEUE_PFN: begin
                        if (q_ok_s) begin
                            q_pfn_r[qi_s] <= w_data_r;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Interrupt status: new events win over an ACK of the same bit; output is a registered OR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_status_r       <= 2'b00;
            virtio_interrupt_r <= 1'b0;
        end else begin
            virtio_interrupt_r <= |int_status_r;
            if (dev_reset_s) begin
                int_status_r <= 2'b00;
            end else begin
                int_status_r <= (int_status_r & ~ack_mask_s) | {config_irq, used_irq};
            end
        end
    end

    virtio_notify_fifo #(
        .WIDTH (QW),
        .DEPTH (NOTIFY_DEPTH)
    ) u_notify_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (dev_reset_s),
        .push      (commit_s && push_req_s),
        .push_data (w_data_r[QW-1:0]),
        .full      (fifo_full_s),
        .pop       (notify_ready),
        .pop_data  (notify_queue),
        .empty     (fifo_empty_s)
    );

endmodule

// File: tb/tb_virtio_mmio_regs.sv
// Directed bench for virtio_mmio_regs: AXI-Lite reads/writes, notify FIFO ordering/stall, interrupts, device reset.
module tb_virtio_mmio_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] core_araddr, core_awaddr, core_wdata, core_rdata;
    logic        core_arvalid, core_arready, core_rvalid, core_rready;
    logic        core_awvalid, core_awready, core_wvalid, core_wready, core_bvalid, core_bready;
    logic [2:0]  core_arprot, core_awprot;
    logic [1:0]  core_rresp, core_bresp;
    logic [3:0]  core_wstrb;
    logic [63:0] capacity;
    logic        notify_valid, notify_ready;
    logic [0:0]  notify_queue;
    logic [63:0] q_pfn, q_num, q_align;
    logic [31:0] guest_page_size;
    logic        used_irq, config_irq, virtio_interrupt, device_reset;

    int          n_pass = 0;
    int          n_total = 0;
    int          dr_count = 0;
    int          dr0;
    logic [31:0] rd_q[$];
    logic [0:0]  note_q[$];
    logic [0:0]  exp_q;

    always #5 clk = ~clk;

    virtio_mmio_regs dut (
        .clk(clk), .rst(rst),
        .core_araddr(core_araddr), .core_arvalid(core_arvalid), .core_arready(core_arready),
        .core_arprot(core_arprot), .core_rdata(core_rdata), .core_rresp(core_rresp),
        .core_rvalid(core_rvalid), .core_rready(core_rready),
        .core_awaddr(core_awaddr), .core_awvalid(core_awvalid), .core_awready(core_awready),
        .core_awprot(core_awprot), .core_wdata(core_wdata), .core_wstrb(core_wstrb),
        .core_wvalid(core_wvalid), .core_wready(core_wready), .core_bresp(core_bresp),
        .core_bvalid(core_bvalid), .core_bready(core_bready),
        .capacity(capacity), .notify_valid(notify_valid), .notify_queue(notify_queue),
        .notify_ready(notify_ready), .q_pfn(q_pfn), .q_num(q_num), .q_align(q_align),
        .guest_page_size(guest_page_size), .used_irq(used_irq), .config_irq(config_irq),
        .virtio_interrupt(virtio_interrupt), .device_reset(device_reset)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Count device_reset cycles.
    always @(negedge clk) begin
        if (!rst && device_reset) dr_count++;
    end

    // Notify pop scoreboard: each pop must match the oldest expected queue index.
    always @(negedge clk) begin
        if (!rst && notify_valid && notify_ready) begin
            n_total++;
            assert (note_q.size() > 0) begin
                n_pass++;
                exp_q = note_q.pop_front();
                check("pop_order", 64'(notify_queue), 64'(exp_q));
            end else $error("FAIL pop_extra: observed pop of %0d expected no pop", notify_queue);
        end
    end

    task automatic rd_start(input logic [31:0] a, input logic [31:0] exp);
        core_araddr  = a;
        core_arvalid = 1'b1;
        rd_q.push_back(exp);
        @(negedge clk);
        core_arvalid = 1'b0;
    endtask

    task automatic rd_finish(input string tag);
        int n = 0;
        logic [31:0] e;
        while (!core_rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        e = rd_q.pop_front();
        check({tag, "_lat"}, 64'(n), 64'd0);
        check(tag, 64'(core_rdata), 64'(e));
        check({tag, "_rresp"}, 64'(core_rresp), 64'd0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        rd_start(a, exp);
        rd_finish(tag);
        @(negedge clk);
    endtask

    task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int w_first);
        core_awaddr = a;
        core_wdata  = d;
        core_wstrb  = s;
        if (w_first != 0) begin
            core_wvalid = 1'b1;
            @(negedge clk);
            core_wvalid  = 1'b0;
            core_awvalid = 1'b1;
            @(negedge clk);
            core_awvalid = 1'b0;
        end else begin
            core_awvalid = 1'b1;
            core_wvalid  = 1'b1;
            @(negedge clk);
            core_awvalid = 1'b0;
            core_wvalid  = 1'b0;
        end
    endtask

    task automatic wait_bresp(input string tag, input int exp_lat);
        int n = 0;
        while (!core_bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_lat >= 0) check({tag, "_blat"}, 64'(n), 64'(exp_lat));
        else check({tag, "_bvalid"}, 64'(core_bvalid), 64'd1);
        check({tag, "_bresp"}, 64'(core_bresp), 64'd0);
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int w_first, input string tag);
        start_write(a, d, s, w_first);
        wait_bresp(tag, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        core_araddr = 32'd0; core_arvalid = 1'b0; core_arprot = 3'd0; core_rready = 1'b1;
        core_awaddr = 32'd0; core_awvalid = 1'b0; core_awprot = 3'd0;
        core_wdata = 32'd0; core_wstrb = 4'h0; core_wvalid = 1'b0; core_bready = 1'b1;
        capacity = 64'h800; notify_ready = 1'b0; used_irq = 1'b0; config_irq = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'({core_arready, core_awready, core_wready}), 64'h7);
        check("rst_valid", 64'({core_rvalid, core_bvalid, notify_valid}), 64'h0);
        check("rst_outs", 64'({virtio_interrupt, device_reset, core_rdata}), 64'h0);
        check("rst_qpfn", q_pfn, 64'h0);
        check("rst_gps", 64'(guest_page_size), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // ID and config reads
        rd(32'h000, 32'h7472_6976, "magic");
        rd(32'h034, 32'd8, "qnummax");
        rd(32'h100, 32'h800, "cap_lo");
        rd(32'h104, 32'h0, "cap_hi");
        rd(32'h008, 32'h2, "devid");
        rd(32'h00C, 32'h554D_4551, "vendor");
        rd(32'h200, 32'h0, "unmapped");

        // W before AW: program queue 1 PFN
        wr(32'h030, 32'd1, 4'hF, 1, "qsel1");
        wr(32'h040, 32'h80012, 4'hF, 1, "pfn");
        check("q_pfn_hi", 64'(q_pfn[63:32]), 64'h80012);
        check("q_pfn_lo", 64'(q_pfn[31:0]), 64'h0);
        rd(32'h040, 32'h80012, "pfn_rd");

        // Read and write of QueueSel landing on the same edge: read sees old value
        start_write(32'h030, 32'd0, 4'hF, 0);
        rd_start(32'h030, 32'd1);
        rd_finish("qsel_rw_old");
        check("qsel_rw_bvalid", 64'(core_bvalid), 64'd1);
        @(negedge clk);
        rd(32'h030, 32'd0, "qsel_new");

        // Partial strobe ignored, full write taken
        wr(32'h028, 32'h1000, 4'h3, 0, "gps_part");
        rd(32'h028, 32'h0, "gps_part_rd");
        wr(32'h028, 32'h1000, 4'hF, 0, "gps");
        rd(32'h028, 32'h1000, "gps_rd");

        // Out-of-range queue select and oversized QueueNum
        wr(32'h030, 32'd5, 4'hF, 0, "qsel5");
        wr(32'h038, 32'd4, 4'hF, 0, "qnum_oor");
        rd(32'h038, 32'd0, "qnum_oor_rd");
        rd(32'h034, 32'd0, "qnummax_oor_rd");
        wr(32'h030, 32'd0, 4'hF, 0, "qsel0");
        wr(32'h038, 32'd9, 4'hF, 0, "qnum9");
        rd(32'h038, 32'd0, "qnum9_rd");
        wr(32'h038, 32'd8, 4'hF, 0, "qnum8");
        rd(32'h038, 32'd8, "qnum8_rd");
        check("q_num0", 64'(q_num[31:0]), 64'd8);
        wr(32'h000, 32'd0, 4'hF, 0, "ro_magic");
        rd(32'h000, 32'h7472_6976, "ro_magic_rd");

        // Interrupts
        used_irq = 1'b1;
        @(negedge clk);
        used_irq = 1'b0;
        check("vi_delay", 64'(virtio_interrupt), 64'd0);
        @(negedge clk);
        check("vi_set", 64'(virtio_interrupt), 64'd1);
        rd(32'h060, 32'd1, "isr1");
        start_write(32'h064, 32'd1, 4'hF, 0);
        used_irq = 1'b1;
        @(negedge clk);
        used_irq = 1'b0;
        wait_bresp("ack_collide", 0);
        rd(32'h060, 32'd1, "isr_collide");
        wr(32'h064, 32'd1, 4'hF, 0, "ack1");
        rd(32'h060, 32'd0, "isr_acked");
        config_irq = 1'b1;
        @(negedge clk);
        config_irq = 1'b0;
        rd(32'h060, 32'd2, "isr_cfg");
        wr(32'h064, 32'd2, 4'hF, 0, "ack2");
        repeat (2) @(negedge clk);
        check("vi_clear", 64'(virtio_interrupt), 64'd0);

        // Notify FIFO: fill, stall the fifth write, then drain in order
        for (int i = 0; i < 4; i++) begin
            note_q.push_back(1'(i % 2 == 0));
            wr(32'h050, 32'((i % 2 == 0) ? 1 : 0), 4'hF, 0, "notify");
        end
        note_q.push_back(1'b1);
        start_write(32'h050, 32'd1, 4'hF, 0);
        repeat (4) @(negedge clk);
        check("notify_stall", 64'(core_bvalid), 64'd0);
        check("notify_valid_full", 64'(notify_valid), 64'd1);
        @(posedge clk);
        #1 notify_ready = 1'b1;
        wait_bresp("notify5", -1);
        repeat (8) @(negedge clk);
        check("notify_drained", 64'(note_q.size()), 64'd0);
        check("notify_empty", 64'(notify_valid), 64'd0);
        @(posedge clk);
        #1 notify_ready = 1'b0;
        @(negedge clk);
        wr(32'h050, 32'd5, 4'hF, 0, "notify_drop");
        check("notify_drop_empty", 64'(notify_valid), 64'd0);
        rd(32'h050, 32'd0, "notify_wo_rd");

        // Device reset via Status=0
        wr(32'h03C, 32'h1000, 4'hF, 0, "qalign");
        wr(32'h020, 32'h55, 4'hF, 0, "gfeat");
        wr(32'h070, 32'hF, 4'hF, 0, "status");
        rd(32'h070, 32'hF, "status_rd");
        note_q.push_back(1'b0);
        wr(32'h050, 32'd0, 4'hF, 0, "notify_pre");
        check("notify_pre_valid", 64'(notify_valid), 64'd1);
        check("no_spurious_dr", 64'(dr_count), 64'd0);
        dr0 = dr_count;
        wr(32'h070, 32'd0, 4'hF, 0, "status0");
        repeat (2) @(negedge clk);
        note_q.delete();
        check("dr_pulse", 64'(dr_count - dr0), 64'd1);
        check("dr_qpfn", q_pfn, 64'h0);
        check("dr_qnum", q_num, 64'h0);
        check("dr_qalign", q_align, 64'h0);
        check("dr_fifo", 64'(notify_valid), 64'd0);
        check("dr_gps", 64'(guest_page_size), 64'h1000);
        rd(32'h070, 32'd0, "dr_status");
        rd(32'h020, 32'd0, "dr_gfeat");
        rd(32'h028, 32'h1000, "dr_gps_rd");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
